// File: rtl/gate_chk_pkg.sv
// Shared types for the gate truth-table checker: sweep FSM states and the
// expected-output lookup into a truth table (supports up to 8 DUT inputs).
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gate_chk_state_t;

  localparam int TRUTH_MAX_W = 256;

  function automatic logic exp_bit(input logic [TRUTH_MAX_W-1:0] truth,
                                   input logic [7:0]             vec);
    return truth[vec];
  endfunction

endpackage

// File: rtl/gate_chk_sat_cnt.sv
// W-bit up counter that sticks at all-ones; synchronous clear beats increment.
// One cycle from inc to visible count; no backpressure.
module gate_chk_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of an N_IN-input gate, settles SETTLE cycles, samples y_i, counts mismatches.
// One vector per SETTLE+1 cycles; start ignored while busy. First-error capture under GATE_CHK_FIRST_ERR_EN.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter logic [2**N_IN-1:0]  TRUTH  = 4'b1000,
  parameter int                  SETTLE = 1,
  parameter int                  ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  vec_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  localparam int TMR_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
  // With no settle time every vector goes straight to its sample cycle.
  localparam gate_chk_state_t  ST_ENTRY = (SETTLE == 0) ? SAMPLE : DRIVE;

  gate_chk_state_t  state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_acc;
  logic             mismatch;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch  = (state_q == SAMPLE) &&
                     (y_i != exp_bit(TRUTH_MAX_W'(TRUTH), 8'(vec_q)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = ST_ENTRY;
      DRIVE:      if (tmr_q == TMR_LAST) state_d = SAMPLE;
      SAMPLE:     state_d = (vec_q == VEC_LAST) ? DONE : ST_ENTRY;
      default:    state_d = IDLE;
    endcase
  end

  // busy/done are registered off the next state so they change with the state itself.
  always_comb begin
    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  always_comb begin
    vec_d = vec_q;
    tmr_d = tmr_q;
    if (start_acc) begin
      vec_d = '0;
      tmr_d = '0;
    end else if (state_q == DRIVE) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else if ((state_q == SAMPLE) && (vec_q != VEC_LAST)) begin
      vec_d = vec_q + N_IN'(1);
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q  <= '0;
      tmr_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      tmr_q  <= tmr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  gate_chk_sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .inc   (mismatch),
    .cnt_o (err_cnt)
  );

`ifdef GATE_CHK_FIRST_ERR_EN
  logic            fe_vld_q, fe_vld_d;
  logic [N_IN-1:0] fe_vec_q, fe_vec_d;

  always_comb begin
    fe_vld_d = fe_vld_q;
    fe_vec_d = fe_vec_q;
    if (start_acc) begin
      fe_vld_d = 1'b0;
      fe_vec_d = '0;
    end else if (mismatch && !fe_vld_q) begin
      fe_vld_d = 1'b1;
      fe_vec_d = vec_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fe_vld_q <= 1'b0;
      fe_vec_q <= '0;
    end else begin
      fe_vld_q <= fe_vld_d;
      fe_vec_q <= fe_vec_d;
    end
  end

  assign first_err_vec   = fe_vec_q;
  assign first_err_valid = fe_vld_q;
`else
  assign first_err_vec   = '0;
  assign first_err_valid = 1'b0;
`endif

  assign vec_o = vec_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pass  = done_q && (err_cnt == '0);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: default AND2 build, saturating N_IN=3 build,
// and SETTLE=0 build; expected vector sequences queued at start, popped each cycle.
module tb_gate_truth_checker;

  logic clk;
  logic rst_n;

  // default build: N_IN=2, TRUTH=AND2, SETTLE=1, ERR_W=8
  logic       start0;
  logic [1:0] vec0;
  logic       y0;
  logic       busy0, done0, pass0, fevld0;
  logic [7:0] err0;
  logic [1:0] fev0;
  logic [1:0] mode0; // 0: correct and2, 1: stuck-at-1, 2: stuck-at-0

  // N_IN=3, TRUTH=0, ERR_W=2, y stuck at 1
  logic       start1;
  logic [2:0] vec1;
  logic       y1;
  logic       busy1, done1, pass1, fevld1;
  logic [1:0] err1;
  logic [2:0] fev1;

  // SETTLE=0, AND2
  logic       start2;
  logic [1:0] vec2;
  logic       y2;
  logic       busy2, done2, pass2, fevld2;
  logic [7:0] err2;
  logic [1:0] fev2;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  assign y0 = (mode0 == 2'd1) ? 1'b1 : (mode0 == 2'd2) ? 1'b0 : (&vec0);
  assign y1 = 1'b1;
  assign y2 = &vec2;

  gate_truth_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec_o(vec0), .y_i(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_vec(fev0), .first_err_valid(fevld0)
  );

  gate_truth_checker #(.N_IN(3), .TRUTH(8'h00), .SETTLE(1), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .vec_o(vec1), .y_i(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_vec(fev1), .first_err_valid(fevld1)
  );

  gate_truth_checker #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(0), .ERR_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_o(vec2), .y_i(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_err_vec(fev2), .first_err_valid(fevld2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // vectors 0..nvec-1, each held for reps cycles
  task automatic push_seq(input int nvec, input int reps);
    for (int v = 0; v < nvec; v++)
      for (int r = 0; r < reps; r++)
        exp_q.push_back(8'(v));
  endtask

  task automatic pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  // Runs cycles 1..8 of a default sweep checking vec/busy/done, then cycle 9 done state.
  task automatic sweep0(input string tag);
    push_seq(4, 2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({tag, "_vec"}, 32'(vec0), 32'(exp_q.pop_front()));
      chk({tag, "_busy"}, 32'(busy0), 32'd1);
      chk({tag, "_done_early"}, 32'(done0), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done0), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy0), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    mode0  = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_vec", 32'(vec0), 32'd0);
    chk("rst_fev", 32'(fev0), 32'd0);
    chk("rst_fevld", 32'(fevld0), 32'd0);
    rst_n = 1'b1;

    // correct AND2
    pulse_start0();
    sweep0("and2");
    chk("and2_err", 32'(err0), 32'd0);
    chk("and2_pass", 32'(pass0), 32'd1);
    chk("and2_fevld", 32'(fevld0), 32'd0);

    // stuck-at-1: mismatches at vectors 0,1,2
    mode0 = 2'd1;
    pulse_start0();
    sweep0("sa1");
    chk("sa1_err", 32'(err0), 32'd3);
    chk("sa1_pass", 32'(pass0), 32'd0);
`ifdef GATE_CHK_FIRST_ERR_EN
    chk("sa1_fev", 32'(fev0), 32'd0);
    chk("sa1_fevld", 32'(fevld0), 32'd1);
`else
    chk("sa1_fev", 32'(fev0), 32'd0);
    chk("sa1_fevld", 32'(fevld0), 32'd0);
`endif

    // stuck-at-0: single mismatch at vector 3
    mode0 = 2'd2;
    pulse_start0();
    sweep0("sa0");
    chk("sa0_err", 32'(err0), 32'd1);
    chk("sa0_pass", 32'(pass0), 32'd0);
`ifdef GATE_CHK_FIRST_ERR_EN
    chk("sa0_fev", 32'(fev0), 32'd3);
    chk("sa0_fevld", 32'(fevld0), 32'd1);
`else
    chk("sa0_fev", 32'(fev0), 32'd0);
    chk("sa0_fevld", 32'(fevld0), 32'd0);
`endif

    // reset mid-sweep while vec_o=2 (errors from vectors 0,1 already counted)
    mode0 = 2'd1;
    pulse_start0();
    repeat (5) @(negedge clk);
    chk("mid_vec", 32'(vec0), 32'd2);
    chk("mid_err", 32'(err0), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 32'(busy0), 32'd0);
    chk("mrst_vec", 32'(vec0), 32'd0);
    chk("mrst_err", 32'(err0), 32'd0);
    chk("mrst_done", 32'(done0), 32'd0);
    chk("mrst_fevld", 32'(fevld0), 32'd0);
    rst_n = 1'b1;
    mode0 = 2'd0;
    pulse_start0();
    sweep0("after_rst");
    chk("after_rst_pass", 32'(pass0), 32'd1);

    // start held high for the whole sweep, then still high in DONE
    @(negedge clk);
    start0 = 1'b1;
    sweep0("held");
    @(negedge clk);
    push_seq(4, 2);
    chk("restart_done", 32'(done0), 32'd0);
    chk("restart_busy", 32'(busy0), 32'd1);
    chk("restart_vec", 32'(vec0), 32'(exp_q.pop_front()));
    start0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("restart_vec", 32'(vec0), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    chk("restart_done_end", 32'(done0), 32'd1);
    chk("restart_pass", 32'(pass0), 32'd1);

    // N_IN=3, TRUTH=0, ERR_W=2: 8 mismatches saturate at 3
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_err_first", 32'(err1), 32'd1);
    chk("sat_busy", 32'(busy1), 32'd1);
    repeat (13) @(negedge clk);
    chk("sat_done_early", 32'(done1), 32'd0);
    chk("sat_vec_last", 32'(vec1), 32'd7);
    @(negedge clk);
    chk("sat_done", 32'(done1), 32'd1);
    chk("sat_err", 32'(err1), 32'd3);
    chk("sat_pass", 32'(pass1), 32'd0);
    chk("sat_vec_hold", 32'(vec1), 32'd7);
`ifdef GATE_CHK_FIRST_ERR_EN
    chk("sat_fevld", 32'(fevld1), 32'd1);
`else
    chk("sat_fevld", 32'(fevld1), 32'd0);
`endif

    // SETTLE=0: one cycle per vector
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    push_seq(4, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s0_vec", 32'(vec2), 32'(exp_q.pop_front()));
      chk("s0_busy", 32'(busy2), 32'd1);
    end
    @(negedge clk);
    chk("s0_done", 32'(done2), 32'd1);
    chk("s0_pass", 32'(pass2), 32'd1);
    chk("s0_err", 32'(err2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Synthesizable self-test engine for small combinational cells such as `and2`. It drives every input vector of an N-input, 1-output gate in ascending order and waits a programmable settle time. It then samples the gate's output and compares it against a parameterised truth table, accumulating mismatches. It is the hardware counterpart of a stimulus testbench: the checking/response end of the DUT interface, usable on silicon or FPGA where no simulator is present.

## Interface
Parameters:
- `N_IN`, default 2: number of DUT inputs; sweeps 2^N_IN vectors.
- `TRUTH`, default 4'b1000: expected output; bit i = expected y for vector i (default = AND2).
- `SETTLE`, default 1: drive-only cycles before each sample (0 allowed).
- `ERR_W`, default 8: error counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin sweep; honoured only in IDLE or DONE.
- `vec_o`, out, N_IN: stimulus to DUT inputs (bit 0 = `a`, bit 1 = `b`).
- `y_i`, in, 1: DUT output.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: sweep complete; held until next accepted start or reset.
- `pass`, out, 1: `done && err_cnt == 0`.
- `err_cnt`, out, ERR_W: mismatch count, saturating.
- `first_err_vec`, out, N_IN: vector of first mismatch (see Configuration).
- `first_err_valid`, out, 1: `first_err_vec` holds a captured value.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start: clear `err_cnt`, `first_err_*`, and `done`; set `vec_o=0` and `timer=0`. Go to DRIVE, or to SAMPLE if SETTLE==0.
- DRIVE: timer counts; after SETTLE cycles in DRIVE, go to SAMPLE.
- SAMPLE (one cycle): compare `y_i` with `TRUTH[vec_o]`. On mismatch, `err_cnt` increments, saturating at 2^ERR_W−1. Then:
  - If `vec_o` is all-ones, go to DONE; `vec_o` holds its last value.
  - Otherwise increment `vec_o` and go to DRIVE (or SAMPLE if SETTLE==0).
- DONE: `done=1`, `busy=0`; results stable.
- `start` while busy is ignored, with no restart and no side effect.
- `y_i` is sampled only in SAMPLE; values in other states are ignored.
- Vector counter is N_IN+0 bits; termination uses the all-ones compare, never counter wrap.

## Timing
- Reset (rst_n low at an edge) forces: state IDLE, `vec_o=0`, `busy=0`, `done=0`, `pass=0`, `err_cnt=0`, `first_err_vec=0`, `first_err_valid=0`. This applies mid-sweep too; the sweep is abandoned.
- Start accepted at edge k: `busy=1` and `vec_o=0` from cycle k+1.
- Each vector occupies SETTLE+1 cycles. `done` rises after edge k + 2^N_IN·(SETTLE+1).
- `busy` and `done` are never both 1.
- All outputs are registered; no combinational path from `y_i` to any output.
- A mismatch in SAMPLE is visible in `err_cnt` in the following cycle.

## Configuration
- `GATE_CHK_FIRST_ERR_EN` defined: on the first mismatch of a sweep, capture `vec_o` into `first_err_vec` and set `first_err_valid=1`. Later mismatches do not overwrite it. Cleared on accepted start and on reset.
- Not defined: capture logic is omitted; `first_err_vec` and `first_err_valid` are tied to 0. Ports remain present.

## Structure
- Package `gate_chk_pkg`: FSM state enum (IDLE, DRIVE, SAMPLE, DONE) and the expected-bit lookup function `exp_bit(truth, vec)`.
- One sub-module, `gate_chk_sat_cnt`: an ERR_W-bit saturating counter with synchronous clear and increment enable, instanced for `err_cnt`.
- Settle timer width: $clog2(SETTLE+1), minimum 1.

## Test plan
- Default params, correct and2 DUT, start pulsed at edge 0:
  - `vec_o` = 0,0,1,1,2,2,3,3 over cycles 1–8.
  - `done=1` from cycle 9; `err_cnt=0`; `pass=1`.
- `y_i` stuck at 1:
  - `err_cnt=3`, `pass=0`.
  - With macro: `first_err_vec=0`, `first_err_valid=1`. Without macro: both 0.
- Reset asserted while `vec_o=2`:
  - Next cycle: `busy=0`, `vec_o=0`, `err_cnt=0`, `done=0`.
  - A fresh start then completes a full 8-cycle sweep.
- `start` held high through the sweep:
  - No restart; `done` still rises at cycle 9.
  - `start` in DONE clears `done` next cycle and repeats the sweep.
- N_IN=3, TRUTH=0, ERR_W=2, `y_i=1`: 8 mismatches; `err_cnt` saturates at 3; `pass=0`.
- SETTLE=0, default truth table, correct DUT: `vec_o` = 0,1,2,3 on cycles 1–4; `done` from cycle 5; `pass=1`.
